pb_operand_adder: RTL and testbench
===================================

// Module: pb_operand_adder
// PURPOSE
//   Parametrised push-button operand adder/subtractor. Operands A and B are entered SW_W bits at
//   a time from the sw switches, using auto-incrementing chunk pointers. Pushbutton edges load the
//   chunks, start the computation or clear the block. Sits between the board pushbutton/switch pins
//   and the LED/7-seg display logic; generalises the fixed 7-bit, 4-button adder to any width, with a mode.
// PARAMETERS
//   WIDTH            7   operand/result width in bits (>=2)
//   SW_W             4   switch-bus width = chunk width (>=1)
//   SYNC_STAGES      2   synchroniser flops per pushbutton (>=2)
//   DEBOUNCE_CYCLES 16   stable cycles required before a button level is accepted (used only with macro)
//   localparam CHUNKS = ceil(WIDTH/SW_W); PTR_W = max(1,clog2(CHUNKS))
// PORTS
//   clk           in   1          system clock, all state on rising edge
//   rstn          in   1          asynchronous active-low reset
//   PB            in   4          raw buttons: [0] load A chunk, [1] load B chunk, [2] compute, [3] clear
//   Y             in   SW_W       switch data for chunk loads
//   mode          in   1          0 = A+B, 1 = A-B; sampled on the compute action cycle
//   A             out  WIDTH      operand A register
//   B             out  WIDTH      operand B register
//   sum           out  WIDTH      registered result
//   carry         out  1          add: carry-out; sub: 1 = no borrow (A>=B unsigned)
//   overflow      out  1          two's-complement signed overflow of the last operation
//   result_valid  out  1          one-cycle pulse when sum/carry/overflow update
//   stale         out  1          1 = A or B changed since the last compute
// BEHAVIOUR
//   - Reset (rstn low, async): A, B, sum, carry, overflow, result_valid, stale, a_ptr, b_ptr,
//     sync/debounce state all -> 0. Reset mid-operation aborts any pending action; no pulse after release.
//   - Input path per button: SYNC_STAGES flop chain -> rising-edge detect (sync_out & ~prev).
//     An action executes on the clk edge where its edge strobe is high. pb[n] first sampled high at
//     edge k -> action at edge k+SYNC_STAGES (k+2 by default). Holding a button gives one action only.
//   - Load A: A[a_ptr*SW_W +: SW_W] <= Y; bits at or above WIDTH in the top chunk are discarded.
//     Then a_ptr <= (a_ptr==CHUNKS-1) ? 0 : a_ptr+1. Load B is identical with b_ptr. Each load sets stale.
//   - Compute: {carry,sum} <= A + (mode ? ~B : B) + mode (WIDTH+1-bit arithmetic).
//     overflow <= (A[MSB]==Bop[MSB]) & (sum[MSB]!=A[MSB]), with Bop = mode ? ~B : B.
//     result_valid <= 1 for exactly one cycle; stale <= 0.
//   - Clear: A, B, sum, carry, overflow, ptrs, stale <= 0; result_valid stays 0.
//   - Simultaneous strobes in one cycle:
//     - clear overrides everything else.
//     - Load A and Load B both execute.
//     - Compute together with a load uses the pre-load A/B; the loaded chunk then lands and stale ends at 1.
//   - Back-to-back computes on consecutive edges are impossible (edge spacing >= 2); each produces its own pulse.
//   - FSM (ctrl): IDLE -> CALC on compute strobe, CALC -> IDLE next cycle (result_valid high in CALC);
//     clear forces IDLE from any state.
// CONFIGURATION
//   PB_OPERAND_ADDER_DEBOUNCE_EN defined:
//     - A per-button counter sits after the synchroniser.
//     - The accepted level changes only after the synchronised input differs from it for
//       DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle resets the counter.
//     - Edge detect runs on the accepted level; latency grows by DEBOUNCE_CYCLES.
//   Not defined: no counters; edge detect directly on the synchroniser output; DEBOUNCE_CYCLES ignored.
// TESTING (WIDTH=7, SW_W=4, defaults)
//   1 Assert rstn low for 3 cycles in the middle of a PB0 press -> all outputs 0, ptrs 0, no load after release.
//   2 Load A: Y=1101 then Y=0101; load B the same; compute with mode=0 -> A=B=1011101,
//     sum=0111010, carry=1, overflow=1, one result_valid pulse, stale=0.
//   3 A=0011001 (Y=1001, Y=0001), B=1011101, mode=1 -> sum=0111100, carry=0, overflow=0.
//   4 Three PB0 presses with Y=1001, 0001, 0111 -> A=0010111 (pointer wrapped to chunk 0), stale=1.
//   5 PB2+PB3 strobes in the same cycle -> everything 0, no pulse.
//     PB2+PB0 in the same cycle -> sum from the old A, A updated, stale=1.
//   6 3-cycle glitch on PB0: with _DEBOUNCE_EN -> A unchanged; without it -> exactly one chunk load.

Source files
------------

// File: rtl/pb_operand_adder.sv
// pb_operand_adder: push-button chunked operand entry with add/subtract, carry and signed overflow.
// Define PB_OPERAND_ADDER_DEBOUNCE_EN to put a per-button debounce counter after the synchroniser.
module pb_operand_adder #(
    parameter int WIDTH           = 7,
    parameter int SW_W            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [3:0]       PB,
    input  logic [SW_W-1:0]  Y,
    input  logic             mode,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             result_valid,
    output logic             stale
);
    localparam int CHUNKS = (WIDTH + SW_W - 1) / SW_W;
    localparam int PTR_W  = CHUNKS > 1 ? $clog2(CHUNKS) : 1;

    typedef enum logic {IDLE, CALC} state_t;

    logic [3:0]       sync_q [SYNC_STAGES];
    logic [3:0]       level, prev, strobe;
    logic [PTR_W-1:0] a_ptr, b_ptr;
    logic [WIDTH-1:0] bop;
    logic [WIDTH:0]   res;
    state_t           state, next_state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= PB;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef PB_OPERAND_ADDER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] cnt [4];
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level <= '0;
            for (int n = 0; n < 4; n++) cnt[n] <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (sync_q[SYNC_STAGES-1][n] != level[n]) begin
                    if (cnt[n] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        level[n] <= sync_q[SYNC_STAGES-1][n];
                        cnt[n]   <= '0;
                    end else begin
                        cnt[n] <= cnt[n] + 1'b1;
                    end
                end else begin
                    cnt[n] <= '0;
                end
            end
        end
    end
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) prev <= '0;
        else       prev <= level;
    end

    assign strobe = level & ~prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    always_comb next_state = strobe[3] ? IDLE : strobe[2] ? CALC : IDLE;

    always_comb result_valid = (state == CALC);

    // Subtraction is A + ~B + 1, so carry set means no borrow.
    always_comb begin
        bop = mode ? ~B : B;
        res = {1'b0, A} + {1'b0, bop} + {{WIDTH{1'b0}}, mode};
    end

    // Insert Y into chunk p; bits landing at or above WIDTH fall off in the truncation.
    function automatic logic [WIDTH-1:0] put(input logic [WIDTH-1:0] r, input logic [PTR_W-1:0] p);
        logic [WIDTH-1:0] m, d;
        m = WIDTH'((WIDTH + SW_W)'({SW_W{1'b1}}) << (p * SW_W));
        d = WIDTH'((WIDTH + SW_W)'(Y) << (p * SW_W));
        return (r & ~m) | d;
    endfunction

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CHUNKS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            A        <= '0;
            B        <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            stale    <= 1'b0;
            a_ptr    <= '0;
            b_ptr    <= '0;
        end else if (strobe[3]) begin
            A        <= '0;
            B        <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            stale    <= 1'b0;
            a_ptr    <= '0;
            b_ptr    <= '0;
        end else begin
            if (strobe[2]) begin
                {carry, sum} <= res;
                overflow     <= (A[WIDTH-1] == bop[WIDTH-1]) & (res[WIDTH-1] != A[WIDTH-1]);
            end
            if (strobe[0]) begin
                A     <= put(A, a_ptr);
                a_ptr <= bump(a_ptr);
            end
            if (strobe[1]) begin
                B     <= put(B, b_ptr);
                b_ptr <= bump(b_ptr);
            end
            if (|strobe[1:0])   stale <= 1'b1;
            else if (strobe[2]) stale <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pb_operand_adder.sv
// tb_pb_operand_adder: directed button sequences checked against a behavioural model and literal results.
// Follows PB_OPERAND_ADDER_DEBOUNCE_EN when the bench is built with it.
module tb_pb_operand_adder;
`ifdef PB_OPERAND_ADDER_DEBOUNCE_EN
    localparam int  DEB = 16;
    localparam bit  CMP = 1'b0;
`else
    localparam int  DEB = 0;
    localparam bit  CMP = 1'b1;
`endif
    localparam int HOLD = DEB + 6;
    localparam int S    = 2;

    logic       clk = 1'b0, rstn = 1'b0, mode = 1'b0;
    logic [3:0] PB = '0, Y = '0;
    logic [6:0] A, B, sum;
    logic       carry, overflow, result_valid, stale;

    int tests = 0, fails = 0, pulses = 0;

    int         ma, mb, ms, mc, mo, mv, mst, pa, pbp;
    logic [3:0] ph [S+1];
    logic [3:0] st;

    pb_operand_adder dut (
        .clk(clk), .rstn(rstn), .PB(PB), .Y(Y), .mode(mode),
        .A(A), .B(B), .sum(sum), .carry(carry), .overflow(overflow),
        .result_valid(result_valid), .stale(stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // A button first seen high S edges ago, low the edge before, acts on this edge.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {ma, mb, ms, mc, mo, mv, mst, pa, pbp} = '{default: 0};
            for (int j = 0; j <= S; j++) ph[j] = '0;
        end else begin
            int sa, sb, r;
            st = ph[S-1] & ~ph[S];
            for (int j = S; j > 0; j--) ph[j] = ph[j-1];
            ph[0] = PB;
            mv = 0;
            if (st[3]) begin
                {ma, mb, ms, mc, mo, mst, pa, pbp} = '{default: 0};
            end else begin
                if (st[2]) begin
                    sa  = ma >= 64 ? ma - 128 : ma;
                    sb  = mb >= 64 ? mb - 128 : mb;
                    r   = mode ? sa - sb : sa + sb;
                    ms  = (mode ? ma - mb : ma + mb) & 127;
                    mc  = mode ? int'(ma >= mb) : int'(ma + mb > 127);
                    mo  = int'(r < -64 || r > 63);
                    mv  = 1;
                    mst = 0;
                end
                if (st[0]) begin
                    ma  = ((ma & ~(15 << (4 * pa))) | (int'(Y) << (4 * pa))) & 127;
                    pa  = (pa + 1) % 2;
                    mst = 1;
                end
                if (st[1]) begin
                    mb  = ((mb & ~(15 << (4 * pbp))) | (int'(Y) << (4 * pbp))) & 127;
                    pbp = (pbp + 1) % 2;
                    mst = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (result_valid) pulses++;
        if (rstn && CMP)
            check("cycle", {7'(A), 7'(B), 7'(sum), carry, overflow, result_valid, stale},
                  {7'(ma), 7'(mb), 7'(ms), mc[0], mo[0], mv[0], mst[0]});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] m, input logic [3:0] y, input logic md);
        int p0;
        p0   = pulses;
        Y    = y;
        mode = md;
        PB   = m;
        tick(HOLD);
        PB = '0;
        tick(HOLD);
        check("pulse_count", pulses - p0, (m[2] && !m[3]) ? 1 : 0);
    endtask

    initial begin
        tick(3);
        rstn = 1'b1;
        tick(2);
        // reset lands mid-press; the button is let go while reset is held
        PB = 4'b0001;
        Y  = 4'b1111;
        tick(1);
        rstn = 1'b0;
        tick(1);
        PB = '0;
        tick(2);
        rstn = 1'b1;
        tick(HOLD);
        check("rst_out", {A, B, sum, carry, overflow, result_valid, stale}, '0);

        press(4'b0001, 4'b1101, 1'b0);
        press(4'b0001, 4'b0101, 1'b0);
        press(4'b0010, 4'b1101, 1'b0);
        press(4'b0010, 4'b0101, 1'b0);
        check("t2_stale_pre", stale, 1);
        press(4'b0100, 4'b0000, 1'b0);
        check("t2_A", A, 7'b1011101);
        check("t2_B", B, 7'b1011101);
        check("t2_sum", sum, 7'b0111010);
        check("t2_carry", carry, 1);
        check("t2_ovf", overflow, 1);
        check("t2_stale", stale, 0);

        press(4'b0001, 4'b1001, 1'b0);
        press(4'b0001, 4'b0001, 1'b0);
        press(4'b0100, 4'b0000, 1'b1);
        check("t3_A", A, 7'b0011001);
        check("t3_sum", sum, 7'b0111100);
        check("t3_carry", carry, 0);
        check("t3_ovf", overflow, 0);

        press(4'b0001, 4'b1001, 1'b0);
        press(4'b0001, 4'b0001, 1'b0);
        press(4'b0001, 4'b0111, 1'b0);
        check("t4_A", A, 7'b0010111);
        check("t4_stale", stale, 1);

        press(4'b1100, 4'b0000, 1'b0);
        check("t5_clear", {A, B, sum, carry, overflow, result_valid, stale}, '0);
        press(4'b0001, 4'b0011, 1'b0);
        press(4'b0010, 4'b0001, 1'b0);
        press(4'b0101, 4'b0101, 1'b0);
        check("t5_sum_old", sum, 7'd4);
        check("t5_A_new", A, 7'h53);
        check("t5_stale", stale, 1);

        PB = 4'b0001;
        Y  = 4'b1111;
        tick(3);
        PB = '0;
        tick(HOLD);
        check("t6_glitch_A", A, DEB > 0 ? 7'h53 : 7'h5F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
